// File: rtl/my_alu_pkg.sv
// Shared opcode encodings and width helpers for the my_alu family.
package my_alu_pkg;

    localparam logic [3:0] OP_ADDU    = 4'b0000;
    localparam logic [3:0] OP_SUBU    = 4'b0001;
    localparam logic [3:0] OP_ADDS    = 4'b0010;
    localparam logic [3:0] OP_SUBS    = 4'b0011;
    localparam logic [3:0] OP_AND     = 4'b0100;
    localparam logic [3:0] OP_OR      = 4'b0101;
    localparam logic [3:0] OP_XOR     = 4'b0110;
    localparam logic [3:0] OP_DIV2    = 4'b0111;
    localparam logic [3:0] OP_SHL     = 4'b1000;
    localparam logic [3:0] OP_SRL     = 4'b1001;
    localparam logic [3:0] OP_SLTU    = 4'b1010;
    localparam logic [3:0] OP_SLT     = 4'b1011;
    localparam logic [3:0] OP_RSVD_LO = 4'b1100;
    localparam logic [3:0] OP_RSVD_HI = 4'b1111;

    function automatic int shw_of(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/my_alu_core.sv
// Combinational ALU datapath: operands and opcode in, result and flags out.
module my_alu_core
    import my_alu_pkg::*;
#(
    parameter int NUMBITS = 8
) (
    input  logic [NUMBITS-1:0] i_a,
    input  logic [NUMBITS-1:0] i_b,
    input  logic [3:0]         i_opcode,
    output logic [NUMBITS-1:0] o_result,
    output logic               o_carryout,
    output logic               o_overflow,
    output logic               o_zero,
    output logic               o_illegal_op
);

    localparam int SHW = shw_of(NUMBITS);

    logic [NUMBITS:0]   w_sum;
    logic [NUMBITS:0]   w_diff;
    logic [NUMBITS:0]   w_shl;
    logic [NUMBITS:0]   w_srl;
    logic [SHW-1:0]     w_sh;
    logic               w_ltu;
    logic               w_lts;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_sh   = i_b[SHW-1:0];
    // The extra bit beside each shift catches the last bit shifted out; it stays 0 for a zero shift.
    assign w_shl  = {1'b0, i_a} << w_sh;
    assign w_srl  = {i_a, 1'b0} >> w_sh;
    assign w_ltu  = (i_a < i_b);
    assign w_lts  = ($signed(i_a) < $signed(i_b));

    // Opcode decode: result and carry/overflow per operation.
    always_comb begin
        o_result     = {NUMBITS{1'b0}};
        o_carryout   = 1'b0;
        o_overflow   = 1'b0;
        o_illegal_op = 1'b0;
        case (i_opcode)
            OP_ADDU: begin
                o_result   = w_sum[NUMBITS-1:0];
                o_carryout = w_sum[NUMBITS];
            end
            OP_SUBU: begin
                o_result   = w_diff[NUMBITS-1:0];
                o_carryout = w_diff[NUMBITS];
            end
            OP_ADDS: begin
                o_result   = w_sum[NUMBITS-1:0];
                o_overflow = (i_a[NUMBITS-1] == i_b[NUMBITS-1]) &&
                             (w_sum[NUMBITS-1] != i_a[NUMBITS-1]);
            end
            OP_SUBS: begin
                o_result   = w_diff[NUMBITS-1:0];
                o_overflow = (i_a[NUMBITS-1] != i_b[NUMBITS-1]) &&
                             (w_diff[NUMBITS-1] != i_a[NUMBITS-1]);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_DIV2: begin
                o_result   = {i_a[NUMBITS-1], i_a[NUMBITS-1:1]};
                o_carryout = i_a[0];
            end
            OP_SHL: begin
                o_result   = w_shl[NUMBITS-1:0];
                o_carryout = w_shl[NUMBITS];
            end
            OP_SRL: begin
                o_result   = w_srl[NUMBITS:1];
                o_carryout = w_srl[0];
            end
            OP_SLTU: o_result = {{(NUMBITS-1){1'b0}}, w_ltu};
            OP_SLT:  o_result = {{(NUMBITS-1){1'b0}}, w_lts};
            default: o_illegal_op = 1'b1;
        endcase
    end

    assign o_zero = (o_result == {NUMBITS{1'b0}});

endmodule

// File: rtl/my_alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a completed-op counter.
module my_alu_pipe
    import my_alu_pkg::*;
#(
    parameter int NUMBITS = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] op_count
);

    logic               r_s1_valid;
    logic [NUMBITS-1:0] r_s1_a;
    logic [NUMBITS-1:0] r_s1_b;
    logic [3:0]         r_s1_op;
    logic               r_s2_valid;
    logic [NUMBITS-1:0] r_result;
    logic               r_carryout;
    logic               r_overflow;
    logic               r_zero;
    logic               r_illegal_op;
    logic [COUNT_W-1:0] r_op_count;

    logic               w_s2_load;
    logic               w_s1_load;
    logic [NUMBITS-1:0] w_result;
    logic               w_carryout;
    logic               w_overflow;
    logic               w_zero;
    logic               w_illegal_op;

    // in_ready follows out_ready combinationally; there is no skid buffer.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    my_alu_core #(.NUMBITS(NUMBITS)) u_core (
        .i_a          (r_s1_a),
        .i_b          (r_s1_b),
        .i_opcode     (r_s1_op),
        .o_result     (w_result),
        .o_carryout   (w_carryout),
        .o_overflow   (w_overflow),
        .o_zero       (w_zero),
        .o_illegal_op (w_illegal_op)
    );

    // Stage 1: capture operands and opcode on an input transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= {NUMBITS{1'b0}};
            r_s1_b     <= {NUMBITS{1'b0}};
            r_s1_op    <= 4'b0000;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= A;
                r_s1_b  <= B;
                r_s1_op <= opcode;
            end
        end
    end

    // Stage 2: register the ALU result and flags; holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid   <= 1'b0;
            r_result     <= {NUMBITS{1'b0}};
            r_carryout   <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
            r_illegal_op <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result     <= w_result;
                r_carryout   <= w_carryout;
                r_overflow   <= w_overflow;
                r_zero       <= w_zero;
                r_illegal_op <= w_illegal_op;
            end
        end
    end

    // Count output transfers, wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count <= {COUNT_W{1'b0}};
        end else if (r_s2_valid && out_ready) begin
            r_op_count <= r_op_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid  = r_s2_valid;
    assign result     = r_result;
    assign carryout   = r_carryout;
    assign overflow   = r_overflow;
    assign zero       = r_zero;
    assign illegal_op = r_illegal_op;
    assign op_count   = r_op_count;

endmodule
